ifft_sdf_bf_stage: RTL and testbench
====================================

Name: ifft_sdf_bf_stage

Overview:
Streaming radix-2 single-path delay-feedback (SDF) butterfly stage for the flow IFFT/FFT datapath. It performs the sum/difference butterfly over sample pairs DEPTH apart, taking one complex sample per valid cycle, with optional divide-by-2 scaling for the inverse direction. Stages are cascaded with DEPTH = N/2, N/4 … 1. Twiddle multiplication happens in a separate downstream stage.
Data is packed {real[CPLX_WIDTH-1:IMGN_WIDTH], imag[IMGN_WIDTH-1:0]}, both two's complement.

Parameters:
REAL_WIDTH, 18, real component width
IMGN_WIDTH, 18, imaginary component width
DEPTH, 8, butterfly span in samples; power of 2, at least 1
SCALE, 1, 1 = each result is (x+1)>>>1 (IFFT 1/N scaling); 0 = full-width result wrapped to component width
CPLX_WIDTH, REAL_WIDTH+IMGN_WIDTH, local, not overridable

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
i_valid  in  1  i_data carries a sample this cycle
i_sop  in  1  with i_valid: this sample is frame index 0
i_data  in  CPLX_WIDTH  input sample
o_valid  out  1  o_data valid this cycle
o_sop  out  1  first output of a frame (first sum)
o_data  out  CPLX_WIDTH  butterfly result

Behaviour:
- Reset (async, any time, including mid-frame): cnt=0, primed=0, delay line all zero, o_valid=0, o_sop=0, o_data=0.
- cnt: log2(2*DEPTH) bits; frame index of the current sample. Advances only on i_valid and wraps 2*DEPTH-1 -> 0. With i_valid & i_sop the sample is index 0 and cnt becomes 1.
- Delay line: DEPTH-entry FIFO (shift register or RAM + pointer) that advances only on i_valid. head = entry written DEPTH valid samples earlier.
- Phase A (index < DEPTH):
  - Push i_data.
  - If primed, output head. This is a difference from the previous frame.
- Phase B (index >= DEPTH):
  - a = head, b = i_data.
  - Output f(a+b) and push f(a-b).
  - Output is always produced.
  - At index DEPTH, o_sop=1 with that output.
- Arithmetic, per component independently:
  - Sign-extend a and b by 1 bit, then add or subtract.
  - SCALE=1: result = (x+1)>>>1. This is round-half-up and cannot overflow.
  - SCALE=0: result = x truncated to width, i.e. two's-complement wrap.
- primed:
  - Set when the index 2*DEPTH-1 sample is accepted.
  - Cleared by reset and by a misaligned i_sop (i_sop while cnt != 0).
- Misaligned i_sop: stored differences are discarded, never emitted. Delay line contents are overwritten naturally. An aligned i_sop (cnt == 0) is a no-op beyond normal operation.
- Outputs are registered; all are updated only in a cycle following an i_valid.
  - o_valid = 1 the cycle after an accepted sample that produces an output, else 0.
  - o_data holds its last value when o_valid=0.
  - o_sop is a 1-cycle pulse qualified by o_valid.
- Timing and order:
  - The sum for input pair (k, k+DEPTH) appears 1 clk after sample k+DEPTH is accepted.
  - The difference appears 1 clk after sample k of the next frame is accepted.
  - Output order per frame: DEPTH sums, then DEPTH differences, interleaved into the next frame's phase A.
  - The last frame's differences need a following frame (or zero-padded flush samples) to drain.
- Gaps in i_valid: all state holds. There is no backpressure; downstream must accept every o_valid.
- i_sop without i_valid is ignored.

Test Plan:
- Reset mid-stream: assert rst during phase B -> o_valid/o_sop/o_data go 0 immediately without clk, cnt=0, primed=0. The next frame's phase A emits nothing.
- DEPTH=4, SCALE=1, frame real 0..7 imag 0, i_sop on first sample, continuous valid:
  - Sums real 2,3,4,5 (imag 0); o_sop with 2; first o_valid 1 clk after sample 4.
  - Second identical frame -> its first 4 outputs are real -2,-2,-2,-2, then sums 2,3,4,5.
- Gapped input: same frame with i_valid toggling 1,0,1,0 -> identical output sequence, o_valid only after valid cycles, o_data stable across gaps.
- SCALE=0, DEPTH=1, REAL_WIDTH=18: a=131071+0j, b=1+0j -> sum real -131072 (wrap); next frame emits difference 131070.
- SCALE=1 rounding: a=-3+5j, b=0+0j -> sum -1+3j; difference -1+3j.
- Misaligned i_sop at index 5 of a primed stream -> no differences emitted in the following phase A. Sums of the new frame are correct and o_sop marks them.

Source files
------------

// File: rtl/ifft_sdf_bf_stage_if.sv
// Complex sample stream into and out of one SDF butterfly stage.
// The stage binds the slave modport; its upstream driver binds the master modport.
interface ifft_sdf_bf_stage_if #(
    parameter int REAL_WIDTH = 18,
    parameter int IMGN_WIDTH = 18
);
    localparam int CPLX_WIDTH = REAL_WIDTH + IMGN_WIDTH;

    logic                  i_valid;
    logic                  i_sop;
    logic [CPLX_WIDTH-1:0] i_data;
    logic                  o_valid;
    logic                  o_sop;
    logic [CPLX_WIDTH-1:0] o_data;

    modport master (
        output i_valid, i_sop, i_data,
        input  o_valid, o_sop, o_data
    );

    modport slave (
        input  i_valid, i_sop, i_data,
        output o_valid, o_sop, o_data
    );
endinterface

// File: rtl/ifft_sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage: sums leave at once,
// differences are recirculated through the delay line and leave one frame later.
module ifft_sdf_bf_stage #(
    parameter int REAL_WIDTH = 18,
    parameter int IMGN_WIDTH = 18,
    parameter int DEPTH      = 8,
    parameter int SCALE      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ifft_sdf_bf_stage_if.slave   bf
);
    localparam int CPLX_WIDTH = REAL_WIDTH + IMGN_WIDTH;
    localparam int CNT_W      = $clog2(2 * DEPTH);
    localparam logic [CNT_W-1:0] IDX_MID  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(2 * DEPTH - 1);

    // SCALE=1 rounds half up and always fits; SCALE=0 wraps the extra bit away.
    function automatic logic signed [REAL_WIDTH-1:0] fin_re(input logic signed [REAL_WIDTH:0] x);
        if (SCALE != 0)
            fin_re = REAL_WIDTH'((x + $signed((REAL_WIDTH+1)'(1))) >>> 1);
        else
            fin_re = REAL_WIDTH'(x);
    endfunction

    function automatic logic signed [IMGN_WIDTH-1:0] fin_im(input logic signed [IMGN_WIDTH:0] x);
        if (SCALE != 0)
            fin_im = IMGN_WIDTH'((x + $signed((IMGN_WIDTH+1)'(1))) >>> 1);
        else
            fin_im = IMGN_WIDTH'(x);
    endfunction

    logic [CNT_W-1:0]      cnt;
    logic                  primed;
    logic [CPLX_WIDTH-1:0] dly [DEPTH];

    logic [CNT_W-1:0]             idx;
    logic                         phase_b;
    logic                         misalign;
    logic                         primed_eff;
    logic [CPLX_WIDTH-1:0]        head;
    logic [CPLX_WIDTH-1:0]        sum_c;
    logic [CPLX_WIDTH-1:0]        diff_c;
    logic [CPLX_WIDTH-1:0]        push_c;
    logic signed [REAL_WIDTH-1:0] a_re, b_re;
    logic signed [IMGN_WIDTH-1:0] a_im, b_im;
    logic signed [REAL_WIDTH:0]   s_re, d_re;
    logic signed [IMGN_WIDTH:0]   s_im, d_im;

    always_comb begin
        idx        = bf.i_sop ? '0 : cnt;
        phase_b    = idx[CNT_W-1];
        misalign   = bf.i_sop && (cnt != '0);
        // A misaligned frame start discards the differences still in flight.
        primed_eff = primed && !misalign;
        head       = dly[DEPTH-1];

        a_re = head[CPLX_WIDTH-1:IMGN_WIDTH];
        a_im = head[IMGN_WIDTH-1:0];
        b_re = bf.i_data[CPLX_WIDTH-1:IMGN_WIDTH];
        b_im = bf.i_data[IMGN_WIDTH-1:0];

        s_re = {a_re[REAL_WIDTH-1], a_re} + {b_re[REAL_WIDTH-1], b_re};
        d_re = {a_re[REAL_WIDTH-1], a_re} - {b_re[REAL_WIDTH-1], b_re};
        s_im = {a_im[IMGN_WIDTH-1], a_im} + {b_im[IMGN_WIDTH-1], b_im};
        d_im = {a_im[IMGN_WIDTH-1], a_im} - {b_im[IMGN_WIDTH-1], b_im};

        sum_c  = {fin_re(s_re), fin_im(s_im)};
        diff_c = {fin_re(d_re), fin_im(d_im)};
        push_c = phase_b ? diff_c : bf.i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            primed     <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                dly[i] <= '0;
            bf.o_valid <= 1'b0;
            bf.o_sop   <= 1'b0;
            bf.o_data  <= '0;
        end else begin
            bf.o_valid <= 1'b0;
            bf.o_sop   <= 1'b0;
            if (bf.i_valid) begin
                cnt <= idx + 1'b1;
                if (misalign)
                    primed <= 1'b0;
                else if (idx == IDX_LAST)
                    primed <= 1'b1;

                dly[0] <= push_c;
                for (int i = 1; i < DEPTH; i++)
                    dly[i] <= dly[i-1];

                if (phase_b) begin
                    bf.o_valid <= 1'b1;
                    bf.o_sop   <= (idx == IDX_MID);
                    bf.o_data  <= sum_c;
                end else if (primed_eff) begin
                    bf.o_valid <= 1'b1;
                    bf.o_data  <= head;
                end
            end
        end
    end
endmodule

// File: tb/tb_ifft_sdf_bf_stage.sv
// Directed bench: a DEPTH=4 rounding stage and a DEPTH=1 wrapping stage.
module tb_ifft_sdf_bf_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;
    int   sums [4] = '{2, 3, 4, 5};
    logic [35:0] held;

    ifft_sdf_bf_stage_if #(.REAL_WIDTH(18), .IMGN_WIDTH(18)) if_a ();
    ifft_sdf_bf_stage_if #(.REAL_WIDTH(18), .IMGN_WIDTH(18)) if_b ();

    ifft_sdf_bf_stage #(.REAL_WIDTH(18), .IMGN_WIDTH(18), .DEPTH(4), .SCALE(1)) dut_a (
        .clk(clk), .rst(rst), .bf(if_a)
    );
    ifft_sdf_bf_stage #(.REAL_WIDTH(18), .IMGN_WIDTH(18), .DEPTH(1), .SCALE(0)) dut_b (
        .clk(clk), .rst(rst), .bf(if_b)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] pk(input int re, input int im);
        return {18'(re), 18'(im)};
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input bit v, input bit s, input int re, input int im);
        if_a.i_valid = v;
        if_a.i_sop   = s;
        if_a.i_data  = pk(re, im);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input bit v, input bit s, input int re, input int im);
        if_b.i_valid = v;
        if_b.i_sop   = s;
        if_b.i_data  = pk(re, im);
        @(posedge clk);
        #1;
    endtask

    task automatic exp_a(input string tag, input bit v, input bit s, input int re, input int im);
        chk({tag, ".vld"}, 36'(if_a.o_valid), 36'(v));
        chk({tag, ".sop"}, 36'(if_a.o_sop), 36'(s));
        if (v) chk({tag, ".data"}, if_a.o_data, pk(re, im));
    endtask

    task automatic exp_b(input string tag, input bit v, input bit s, input int re, input int im);
        chk({tag, ".vld"}, 36'(if_b.o_valid), 36'(v));
        chk({tag, ".sop"}, 36'(if_b.o_sop), 36'(s));
        if (v) chk({tag, ".data"}, if_b.o_data, pk(re, im));
    endtask

    initial begin
        if_a.i_valid = 1'b0; if_a.i_sop = 1'b0; if_a.i_data = '0;
        if_b.i_valid = 1'b0; if_b.i_sop = 1'b0; if_b.i_data = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_a("rst", 1'b0, 1'b0, 0, 0);
        chk("rst.data", if_a.o_data, '0);
        rst = 1'b0;

        // Frame 1: real 0..7, nothing to emit in phase A
        for (int k = 0; k < 8; k++) begin
            drive_a(1'b1, k == 0, k, 0);
            if (k < 4) exp_a("f1_a", 1'b0, 1'b0, 0, 0);
            else       exp_a("f1_sum", 1'b1, k == 4, sums[k-4], 0);
        end

        // Frame 2: identical, previous differences drain first
        for (int k = 0; k < 8; k++) begin
            drive_a(1'b1, k == 0, k, 0);
            if (k < 4) exp_a("f2_diff", 1'b1, 1'b0, -2, 0);
            else       exp_a("f2_sum", 1'b1, k == 4, sums[k-4], 0);
        end

        // Frame 3: gapped valid, outputs hold across idle cycles
        for (int k = 0; k < 8; k++) begin
            drive_a(1'b1, k == 0, k, 0);
            if (k < 4) exp_a("f3_diff", 1'b1, 1'b0, -2, 0);
            else       exp_a("f3_sum", 1'b1, k == 4, sums[k-4], 0);
            held = (k < 4) ? pk(-2, 0) : pk(sums[k-4], 0);
            drive_a(1'b0, 1'b0, 99, 99);
            exp_a("f3_gap", 1'b0, 1'b0, 0, 0);
            chk("f3_gap.hold", if_a.o_data, held);
        end

        // Frame 4 cut short at index 5, then a misaligned sop
        for (int k = 0; k < 6; k++) begin
            drive_a(1'b1, k == 0, k, 0);
            if (k < 4) exp_a("f4_diff", 1'b1, 1'b0, -2, 0);
            else       exp_a("f4_sum", 1'b1, k == 4, sums[k-4], 0);
        end
        for (int k = 0; k < 8; k++) begin
            drive_a(1'b1, k == 0, 10 + k, 0);
            if (k < 4) exp_a("mis_a", 1'b0, 1'b0, 0, 0);
            else       exp_a("mis_sum", 1'b1, k == 4, 8 + k, 0);
        end

        // Rounding: a=-3+5j, b=0
        drive_a(1'b1, 1'b1, -3, 5);
        exp_a("rnd_diff0", 1'b1, 1'b0, -2, 0);
        for (int k = 1; k < 4; k++) begin
            drive_a(1'b1, 1'b0, 0, 0);
            exp_a("rnd_diff", 1'b1, 1'b0, -2, 0);
        end
        drive_a(1'b1, 1'b0, 0, 0);
        exp_a("rnd_sum0", 1'b1, 1'b1, -1, 3);
        for (int k = 5; k < 8; k++) begin
            drive_a(1'b1, 1'b0, 0, 0);
            exp_a("rnd_sum", 1'b1, 1'b0, 0, 0);
        end
        drive_a(1'b1, 1'b1, 0, 0);
        exp_a("flush_diff0", 1'b1, 1'b0, -1, 3);
        for (int k = 1; k < 8; k++) begin
            drive_a(1'b1, 1'b0, 0, 0);
            exp_a("flush", 1'b1, k == 4, 0, 0);
        end

        // Reset in phase B, then a frame started from cnt alone
        for (int k = 0; k < 6; k++) begin
            drive_a(1'b1, k == 0, k, 0);
            if (k < 4) exp_a("pre_rst_diff", 1'b1, 1'b0, 0, 0);
            else       exp_a("pre_rst_sum", 1'b1, k == 4, sums[k-4], 0);
        end
        if_a.i_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        exp_a("mid_rst", 1'b0, 1'b0, 0, 0);
        chk("mid_rst.data", if_a.o_data, '0);
        #2 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive_a(1'b1, 1'b0, k, 0);
            if (k < 4) exp_a("post_rst_a", 1'b0, 1'b0, 0, 0);
            else       exp_a("post_rst_sum", 1'b1, k == 4, sums[k-4], 0);
        end
        drive_a(1'b0, 1'b0, 0, 0);

        // DEPTH=1, wrapping arithmetic
        drive_b(1'b1, 1'b1, 131071, 0);
        exp_b("wrap_a", 1'b0, 1'b0, 0, 0);
        drive_b(1'b1, 1'b0, 1, 0);
        exp_b("wrap_sum", 1'b1, 1'b1, -131072, 0);
        drive_b(1'b1, 1'b1, 0, 0);
        exp_b("wrap_diff", 1'b1, 1'b0, 131070, 0);
        drive_b(1'b1, 1'b0, 0, 0);
        exp_b("wrap_sum2", 1'b1, 1'b1, 0, 0);
        drive_b(1'b0, 1'b0, 0, 0);
        exp_b("wrap_idle", 1'b0, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
